rgb_palette_fader: RTL and testbench

- Parametrised successor to the fixed 3-bit colour-to-RGB converter.
- Maps a colour index to a packed R/G/B word through a writable palette of 2^IDX_W entries, each channel CH_W bits wide.
- Snap mode: the output jumps to the target colour in one cycle.
- Fade mode: the output ramps toward the target by STEP per channel per cycle.
- Sits between the control logic that issues colour indices and the LED/display driver.

---
 rtl/rgb_palette_fader_if.sv | 38 +++
 rtl/rgb_palette_fader.sv | 126 ++++++++++++
 tb/tb_rgb_palette_fader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rgb_palette_fader_if.sv
// -----------------------------------------------------------------------------
// rgb_palette_fader_if
// Purpose : groups the colour-request, palette-write and colour-output signals
//           of rgb_palette_fader into one bundle.
// Signals : enable, colour, fade       - colour request from control logic
//           wr_en, wr_addr, wr_data    - palette write port
//           rgb, settled               - registered colour towards LED driver
//           state_dbg                  - fader FSM state (0 IDLE, 1 RAMP)
// Modports: master - control side (drives requests/writes, observes outputs)
//           slave  - the fader itself
// Handshake: there is no valid/ready pair. Every cycle with enable=1 is one
//           accepted request; enable=0 holds all outputs. wr_en is a
//           single-cycle write strobe that is always accepted.
// -----------------------------------------------------------------------------
interface rgb_palette_fader_if #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
);
  logic                enable;
  logic [IDX_W-1:0]    colour;
  logic                fade;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [3*CH_W-1:0]   wr_data;
  logic [3*CH_W-1:0]   rgb;
  logic                settled;
  logic                state_dbg;

  modport master (
    output enable, colour, fade, wr_en, wr_addr, wr_data,
    input  rgb, settled, state_dbg
  );

  modport slave (
    input  enable, colour, fade, wr_en, wr_addr, wr_data,
    output rgb, settled, state_dbg
  );
endinterface

// File: rtl/rgb_palette_fader.sv
// -----------------------------------------------------------------------------
// rgb_palette_fader
// Purpose : maps a colour index to a packed {R,G,B} word through a writable
//           palette of 2^IDX_W entries and either snaps to the target colour
//           or ramps towards it by STEP per channel per enabled cycle.
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous active-high reset (palette defaults, rgb=0)
//           bus  - rgb_palette_fader_if.slave (see interface header)
// Option  : RGB_PALETTE_FADE_EN - when defined, fade mode and the RAMP state
//           exist. When undefined, fade is ignored, every enabled cycle is a
//           snap and settled is constant 1.
// -----------------------------------------------------------------------------
module rgb_palette_fader #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8,
  parameter int STEP  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_palette_fader_if.slave    bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int RGB_W = 3 * CH_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  logic [RGB_W-1:0] r_pal [DEPTH];
  logic [RGB_W-1:0] r_rgb;
  state_t           r_state;

  logic [RGB_W-1:0] w_target;
  logic [RGB_W-1:0] w_rgb_next;
  state_t           w_state_next;

  // Entries 0..7 follow the legacy 3-bit code: bit2=R, bit1=G, bit0=B.
  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    logic [2:0] b;
    b = idx[2:0];
    if (idx < 8) return {{CH_W{b[2]}}, {CH_W{b[1]}}, {CH_W{b[0]}}};
    else         return '0;
  endfunction

  // Palette: write strobe is independent of enable. Lookups are combinational
  // reads of the registered array, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pal[i] <= default_entry(i);
    end else if (bus.wr_en) begin
      r_pal[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_target = r_pal[bus.colour];

`ifdef RGB_PALETTE_FADE_EN
  localparam logic [CH_W:0] L_STEP = (CH_W+1)'(STEP);

  // One channel step. The distance is taken in CH_W+1 bits and clamped to
  // STEP, so the channel lands exactly on the target and never wraps.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] cur,
                                               input logic [CH_W-1:0] tgt);
    logic [CH_W:0] d;
    if (cur < tgt) begin
      d = {1'b0, tgt} - {1'b0, cur};
      if (d > L_STEP) d = L_STEP;
      return cur + d[CH_W-1:0];
    end else begin
      d = {1'b0, cur} - {1'b0, tgt};
      if (d > L_STEP) d = L_STEP;
      return cur - d[CH_W-1:0];
    end
  endfunction

  logic [RGB_W-1:0] w_faded;

  always_comb begin
    w_faded = '0;
    for (int c = 0; c < 3; c++) begin
      w_faded[c*CH_W +: CH_W] = fade_ch(r_rgb[c*CH_W +: CH_W],
                                        w_target[c*CH_W +: CH_W]);
    end
  end

  always_comb begin
    w_rgb_next   = r_rgb;
    w_state_next = r_state;
    if (bus.enable) begin
      if (bus.fade) begin
        w_rgb_next   = w_faded;
        w_state_next = (w_faded == w_target) ? ST_IDLE : ST_RAMP;
      end else begin
        w_rgb_next   = w_target;
        w_state_next = ST_IDLE;
      end
    end
  end

  assign bus.settled = (r_state == ST_IDLE);
`else
  always_comb begin
    w_rgb_next   = r_rgb;
    w_state_next = ST_IDLE;
    if (bus.enable) w_rgb_next = w_target;
  end

  assign bus.settled = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_rgb   <= w_rgb_next;
      r_state <= w_state_next;
    end
  end

  assign bus.rgb       = r_rgb;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_rgb_palette_fader.sv
module tb_rgb_palette_fader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rgb_palette_fader_if #(.IDX_W(3), .CH_W(8)) bus ();

  rgb_palette_fader #(.IDX_W(3), .CH_W(8), .STEP(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [23:0] snap_exp [8];
  logic [7:0]  lvl;
  logic [23:0] hold_val;

  initial begin
    checks   = 0;
    failures = 0;
    snap_exp[0] = 24'h000000; snap_exp[1] = 24'h0000FF;
    snap_exp[2] = 24'h00FF00; snap_exp[3] = 24'h00FFFF;
    snap_exp[4] = 24'hFF0000; snap_exp[5] = 24'hFF00FF;
    snap_exp[6] = 24'hFFFF00; snap_exp[7] = 24'hFFFFFF;

    // Reset for two cycles with enable high.
    rst         = 1'b1;
    bus.enable  = 1'b1;
    bus.colour  = 3'd7;
    bus.fade    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 24'h0;
    tick();
    check24("reset_rgb_1", bus.rgb, 24'h000000);
    check1 ("reset_settled_1", bus.settled, 1'b1);
    tick();
    check24("reset_rgb_2", bus.rgb, 24'h000000);
    rst = 1'b0;

    // Snap sweep through the default palette.
    for (int i = 0; i < 8; i++) begin
      bus.colour = 3'(i);
      tick();
      check24($sformatf("snap_%0d", i), bus.rgb, snap_exp[i]);
      check1 ($sformatf("snap_settled_%0d", i), bus.settled, 1'b1);
    end

    // enable low holds the output.
    bus.enable = 1'b0;
    bus.colour = 3'd1;
    tick();
    tick();
    check24("hold_disabled", bus.rgb, 24'hFFFFFF);

    // Same-cycle write and lookup: old data first, new data next cycle.
    bus.enable  = 1'b1;
    bus.colour  = 3'd2;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 24'h123456;
    tick();
    bus.wr_en = 1'b0;
    check24("collision_old", bus.rgb, 24'h00FF00);
    tick();
    check24("collision_new", bus.rgb, 24'h123456);

    // Fade up from black to white.
    bus.colour = 3'd0;
    tick();
    check24("fade_start_black", bus.rgb, 24'h000000);
    bus.colour = 3'd7;
    bus.fade   = 1'b1;
`ifdef RGB_PALETTE_FADE_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      lvl = 8'(16 * k);
      check24($sformatf("fade_up_%0d", k), bus.rgb, {lvl, lvl, lvl});
      check1 ($sformatf("fade_up_settled_%0d", k), bus.settled, 1'b0);
      if (k == 5) begin
        bus.enable = 1'b0;
        tick(); tick(); tick();
        check24("fade_freeze_rgb", bus.rgb, 24'h505050);
        check1 ("fade_freeze_settled", bus.settled, 1'b0);
        bus.enable = 1'b1;
      end
    end
    tick();
    check24("fade_up_final", bus.rgb, 24'hFFFFFF);
    check1 ("fade_up_final_settled", bus.settled, 1'b1);
`else
    tick();
    check24("nofade_white", bus.rgb, 24'hFFFFFF);
    check1 ("nofade_settled", bus.settled, 1'b1);
    tick();
    check24("nofade_white_hold", bus.rgb, 24'hFFFFFF);
`endif

    // Retarget mid-ramp, then reset mid-ramp.
    bus.fade   = 1'b0;
    bus.colour = 3'd0;
    tick();
    check24("retarget_start_black", bus.rgb, 24'h000000);
    bus.fade   = 1'b1;
    bus.colour = 3'd7;
`ifdef RGB_PALETTE_FADE_EN
    for (int k = 1; k <= 15; k++) tick();
    check24("retarget_at_f0", bus.rgb, 24'hF0F0F0);
    bus.colour = 3'd4;
    tick();
    check24("retarget_clamp", bus.rgb, 24'hFFE0E0);
    check1 ("retarget_settled", bus.settled, 1'b0);
    tick();
    check24("retarget_step2", bus.rgb, 24'hFFD0D0);
`else
    tick();
    hold_val = bus.rgb;
    check24("nofade_retarget_white", hold_val, 24'hFFFFFF);
    bus.colour = 3'd4;
    tick();
    check24("nofade_retarget_red", bus.rgb, 24'hFF0000);
    check1 ("nofade_retarget_settled", bus.settled, 1'b1);
`endif
    rst = 1'b1;
    tick();
    check24("midramp_reset_rgb", bus.rgb, 24'h000000);
    check1 ("midramp_reset_settled", bus.settled, 1'b1);
    rst        = 1'b0;
    bus.fade   = 1'b0;
    bus.colour = 3'd2;
    tick();
    check24("palette_restored", bus.rgb, 24'h00FF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
